// File: rtl/eq_controller_pkg.sv
// Shared constants, state encodings and types for the histogram-equalization sequencer.
package eq_pkg;

    localparam int unsigned NBINS   = 8;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned CNT_W   = 14;
    localparam int unsigned LUT_MAX = 255;
    localparam int unsigned DIV_W   = 22;

    localparam int unsigned BIN_W   = $clog2(NBINS);
    localparam int unsigned LANES   = 4;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DIM_W   = 7;
    localparam int unsigned HADDR_W = 6;
    localparam int unsigned PADDR_W = 14;
    localparam int unsigned HCNT_W  = BIN_W + 1;
    localparam int unsigned DCNT_W  = 5;
    localparam int unsigned ITER_W  = 5;
    localparam int unsigned ST_W    = 3;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HREAD = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] PRD   = 3'd3;
    localparam logic [2:0] PWR   = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

    typedef logic [LANES-1:0][PIX_W-1:0] pix_word_t;

    // Bin index of a pixel is its top BIN_W bits.
    function automatic logic [BIN_W-1:0] pix_bin(input logic [PIX_W-1:0] p);
        return BIN_W'(p >> (PIX_W - BIN_W));
    endfunction

endpackage

// File: rtl/eq_controller_if.sv
// Memory and handshake bundle between the equalizer and its histogram/pixel RAMs.
interface eq_controller_if;
    import eq_pkg::*;

    logic                 start;
    logic [DIM_W-1:0]     dim;
    logic [WORD_W-1:0]    hist_rd_data;
    logic [HADDR_W-1:0]   addr_hist;
    logic [WORD_W-1:0]    pix_rd_data;
    logic [PADDR_W-1:0]   addr_pix;
    logic                 WE_out;
    logic [PADDR_W-1:0]   addr_out;
    logic [WORD_W-1:0]    dataout_out;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, dim, hist_rd_data, pix_rd_data,
        output addr_hist, addr_pix, WE_out, addr_out, dataout_out, busy, done
    );

    modport slave (
        output start, dim, hist_rd_data, pix_rd_data,
        input  addr_hist, addr_pix, WE_out, addr_out, dataout_out, busy, done
    );

endinterface

// File: rtl/eq_controller_seq_div.sv
// Restoring divider: one load cycle on go, then DIV_W iterations, done pulses once.
module seq_div
    import eq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [DIV_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic [DIV_W-1:0]  quotient,
    output logic              done
);

    logic [CNT_W-1:0]  rem;
    logic [DIV_W-1:0]  quo;
    logic [CNT_W-1:0]  dvs;
    logic [ITER_W-1:0] cnt;
    logic              run;

    logic [CNT_W:0]    shifted_c;
    logic [CNT_W:0]    diff_c;
    logic              ge_c;
    logic [CNT_W-1:0]  rem_step_c;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted_c  = {rem, quo[DIV_W-1]};
        diff_c     = shifted_c - {1'b0, dvs};
        ge_c       = (shifted_c >= {1'b0, dvs});
        rem_step_c = CNT_W'(ge_c ? diff_c : shifted_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                rem <= '0;
                quo <= dividend;
                dvs <= divisor;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                rem <= rem_step_c;
                quo <= {quo[DIV_W-2:0], ge_c};
                cnt <= cnt + ITER_W'(1);
                if (cnt == ITER_W'(DIV_W - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/eq_controller.sv
// Histogram-equalization sequencer: CDF build, LUT division, then pixel remap stream.
module eq_controller
    import eq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    eq_controller_if.master bus
);

    logic [ST_W-1:0]    state, state_n;
    logic [CNT_W-1:0]   total_q, total_n;
    logic [PADDR_W-1:0] words_q, words_n;
    logic [HCNT_W-1:0]  hcnt, hcnt_n;
    logic [CNT_W-1:0]   cdf, cdf_n;
    logic [DCNT_W-1:0]  dcnt, dcnt_n;
    logic [BIN_W-1:0]   bin_idx, bin_n;
    logic [BIN_W-1:0]   lut_idx, lut_idx_n;
    logic [PADDR_W-1:0] w, w_n;

    logic [CNT_W-1:0]   cdf_reg [NBINS];
    logic [PIX_W-1:0]   lut     [NBINS];

    logic               cdf_we;
    logic [BIN_W-1:0]   cdf_widx;
    logic [CNT_W-1:0]   cdf_sum_c;
    logic [CNT_W-1:0]   sq_c;

    logic [HADDR_W-1:0] addr_hist_q, addr_hist_n;
    logic [PADDR_W-1:0] addr_pix_q, addr_pix_n;
    logic               we_q, we_n;
    logic [PADDR_W-1:0] addr_out_q, addr_out_n;
    logic [WORD_W-1:0]  dataout_q, dataout_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;

    logic               div_go_c;
    logic [DIV_W-1:0]   dividend_c;
    logic [DIV_W-1:0]   div_q;
    logic               div_done;
    logic [PIX_W-1:0]   lut_wr_c;

    pix_word_t          pw_c, map_c;

    seq_div u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (div_go_c),
        .dividend (dividend_c),
        .divisor  (total_q),
        .quotient (div_q),
        .done     (div_done)
    );

    // cdf*255 formed as (cdf<<8) - cdf.
    assign dividend_c = DIV_W'({cdf_reg[bin_idx], PIX_W'(0)}) - DIV_W'(cdf_reg[bin_idx]);
    assign lut_wr_c   = (div_q > DIV_W'(LUT_MAX)) ? PIX_W'(LUT_MAX) : PIX_W'(div_q);
    assign sq_c       = CNT_W'(bus.dim) * CNT_W'(bus.dim);
    // Only the low CNT_W bits of the sum survive, so upper RAM bits have no effect.
    assign cdf_sum_c  = CNT_W'(WORD_W'(cdf) + bus.hist_rd_data);

    always_comb begin
        map_c = '0;
        pw_c  = pix_word_t'(bus.pix_rd_data);
        for (int i = 0; i < LANES; i++) begin
            map_c[i] = lut[pix_bin(pw_c[i])];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        total_n    = total_q;
        words_n    = words_q;
        hcnt_n     = hcnt;
        cdf_n      = cdf;
        dcnt_n     = dcnt;
        bin_n      = bin_idx;
        w_n        = w;
        lut_idx_n  = div_done ? (lut_idx + BIN_W'(1)) : lut_idx;
        cdf_we     = 1'b0;
        cdf_widx   = BIN_W'(hcnt - HCNT_W'(1));
        div_go_c   = 1'b0;
        we_n       = 1'b0;
        addr_out_n = addr_out_q;
        dataout_n  = dataout_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    total_n   = sq_c;
                    words_n   = PADDR_W'(sq_c >> 2);
                    hcnt_n    = '0;
                    cdf_n     = '0;
                    lut_idx_n = '0;
                    state_n   = (bus.dim == '0) ? FIN : HREAD;
                end
            end
            HREAD: begin
                // Data for address hcnt-1 arrives while address hcnt is driven.
                if (hcnt != '0) begin
                    cdf_n  = cdf_sum_c;
                    cdf_we = 1'b1;
                end
                if (hcnt == HCNT_W'(NBINS)) begin
                    state_n = DIV;
                    dcnt_n  = '0;
                    bin_n   = '0;
                end else begin
                    hcnt_n = hcnt + HCNT_W'(1);
                end
            end
            DIV: begin
                // Each bin gets one load cycle plus DIV_W iteration cycles.
                div_go_c = (dcnt == '0);
                if (dcnt == DCNT_W'(DIV_W)) begin
                    dcnt_n = '0;
                    if (bin_idx == BIN_W'(NBINS - 1)) begin
                        state_n = PRD;
                        w_n     = '0;
                    end else begin
                        bin_n = bin_idx + BIN_W'(1);
                    end
                end else begin
                    dcnt_n = dcnt + DCNT_W'(1);
                end
            end
            PRD: begin
                state_n = PWR;
            end
            PWR: begin
                we_n       = 1'b1;
                addr_out_n = w;
                dataout_n  = map_c;
                if (w == words_q - PADDR_W'(1)) begin
                    state_n = FIN;
                end else begin
                    w_n     = w + PADDR_W'(1);
                    state_n = PRD;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        addr_hist_n = (state_n == HREAD && hcnt_n < HCNT_W'(NBINS)) ? HADDR_W'(hcnt_n) : '0;
        addr_pix_n  = (state_n == PRD) ? w_n : '0;
        busy_n      = (state_n != IDLE);
        done_n      = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q     <= '0;
            words_q     <= '0;
            hcnt        <= '0;
            cdf         <= '0;
            dcnt        <= '0;
            bin_idx     <= '0;
            lut_idx     <= '0;
            w           <= '0;
            addr_hist_q <= '0;
            addr_pix_q  <= '0;
            we_q        <= 1'b0;
            addr_out_q  <= '0;
            dataout_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NBINS; i++) begin
                cdf_reg[i] <= '0;
                lut[i]     <= '0;
            end
        end else begin
            total_q     <= total_n;
            words_q     <= words_n;
            hcnt        <= hcnt_n;
            cdf         <= cdf_n;
            dcnt        <= dcnt_n;
            bin_idx     <= bin_n;
            lut_idx     <= lut_idx_n;
            w           <= w_n;
            addr_hist_q <= addr_hist_n;
            addr_pix_q  <= addr_pix_n;
            we_q        <= we_n;
            addr_out_q  <= addr_out_n;
            dataout_q   <= dataout_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            if (cdf_we)   cdf_reg[cdf_widx] <= cdf_n;
            if (div_done) lut[lut_idx]      <= lut_wr_c;
        end
    end

    assign bus.addr_hist   = addr_hist_q;
    assign bus.addr_pix    = addr_pix_q;
    assign bus.WE_out      = we_q;
    assign bus.addr_out    = addr_out_q;
    assign bus.dataout_out = dataout_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_eq_controller.sv
// Directed bench for eq_controller: job table plus abort/restart and start-while-busy sequences.
module tb_eq_controller;

    typedef struct packed {
        logic [6:0]      dim;
        logic [1:0]      pat;
        logic [7:0][7:0] lut;
        logic [15:0]     cycles;
    } vec_t;

    localparam int LIMIT = 2000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   done_cnt;
    int   viol;
    int   hist_nz;
    logic prev_we;

    logic [31:0] hist_mem [64];
    logic [31:0] pix_mem  [16384];
    logic [13:0] wq_addr [$];
    logic [31:0] wq_data [$];
    vec_t        vecs [5];

    eq_controller_if bus ();

    eq_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.hist_rd_data <= hist_mem[bus.addr_hist];
        bus.pix_rd_data  <= pix_mem[bus.addr_pix];
    end

    always @(negedge clk) begin
        if (bus.WE_out) begin
            wq_addr.push_back(bus.addr_out);
            wq_data.push_back(bus.dataout_out);
            if (prev_we) viol++;
        end
        prev_we = bus.WE_out;
        if (bus.done) done_cnt++;
        if (bus.done && bus.busy) viol++;
        if (bus.addr_hist != 6'd0) hist_nz++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pix_word(input logic [1:0] pat, input int w);
        logic [31:0] r;
        r = '0;
        case (pat)
            2'd0: for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(((w + i) % 8) << 5);
            2'd1: r = 32'h4040_4040;
            2'd2: r = (w < 3) ? 32'h0000_0000 : 32'hFFFF_FFFF;
            default: r = 32'hE0A0_6000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input vec_t v, input logic [31:0] wd);
        logic [31:0] r;
        logic [7:0]  lane;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            lane = wd[i*8 +: 8];
            r[i*8 +: 8] = v.lut[lane[7:5]];
        end
        return r;
    endfunction

    task automatic load_mem(input vec_t v);
        int words;
        logic [31:0] wd;
        logic [7:0]  lane;
        words = (int'(v.dim) * int'(v.dim)) / 4;
        for (int b = 0; b < 64; b++) hist_mem[b] = '0;
        for (int k = 0; k < 64; k++) pix_mem[k] = 32'hDEAD_BEEF;
        for (int k = 0; k < words; k++) begin
            wd = pix_word(v.pat, k);
            pix_mem[k] = wd;
            for (int i = 0; i < 4; i++) begin
                lane = wd[i*8 +: 8];
                hist_mem[lane[7:5]] = hist_mem[lane[7:5]] + 32'd1;
            end
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_we"},        32'(bus.WE_out),      32'd0);
        chk({pfx, "_busy"},      32'(bus.busy),        32'd0);
        chk({pfx, "_done"},      32'(bus.done),        32'd0);
        chk({pfx, "_addr_hist"}, 32'(bus.addr_hist),   32'd0);
        chk({pfx, "_addr_pix"},  32'(bus.addr_pix),    32'd0);
        chk({pfx, "_addr_out"},  32'(bus.addr_out),    32'd0);
        chk({pfx, "_dataout"},   bus.dataout_out,      32'd0);
    endtask

    task automatic run_job(input vec_t v, input int inject_at);
        int n;
        int words;
        words = (int'(v.dim) * int'(v.dim)) / 4;
        load_mem(v);
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        viol     = 0;
        hist_nz  = 0;
        bus.dim   = v.dim;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dim   = 7'd100;
        n = 1;
        chk("busy_rise", 32'(bus.busy), 32'd1);
        while (!bus.done && n < LIMIT) begin
            bus.start = (n == inject_at);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("done_timeout", 32'(n < LIMIT), 32'd1);
        chk("start_to_done", 32'(n), 32'(v.cycles));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        repeat (30) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("write_count", 32'(wq_addr.size()), 32'(words));
        chk("we_spacing_done_busy", 32'(viol), 32'd0);
        if (v.dim == 7'd0) chk("hist_addr_idle", 32'(hist_nz), 32'd0);
        for (int k = 0; k < words && k < wq_addr.size(); k++) begin
            chk("wr_addr", 32'(wq_addr[k]), 32'(k));
            chk("wr_data", wq_data[k], exp_word(v, pix_word(v.pat, k)));
        end
    endtask

    initial begin
        int n;
        errors    = 0;
        checks    = 0;
        done_cnt  = 0;
        viol      = 0;
        hist_nz   = 0;
        prev_we   = 1'b0;
        bus.start = 1'b0;
        bus.dim   = 7'd0;
        for (int b = 0; b < 64; b++) hist_mem[b] = '0;
        for (int k = 0; k < 16384; k++) pix_mem[k] = '0;

        vecs[0] = '{dim: 7'd8, pat: 2'd0,
                    lut: {8'd255, 8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31},
                    cycles: 16'd227};
        vecs[1] = '{dim: 7'd4, pat: 2'd1,
                    lut: {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0},
                    cycles: 16'd203};
        vecs[2] = '{dim: 7'd6, pat: 2'd2,
                    lut: {8'd255, 8'd85, 8'd85, 8'd85, 8'd85, 8'd85, 8'd85, 8'd85},
                    cycles: 16'd213};
        vecs[3] = '{dim: 7'd0, pat: 2'd1, lut: '0, cycles: 16'd2};
        vecs[4] = '{dim: 7'd2, pat: 2'd3,
                    lut: {8'd255, 8'd191, 8'd191, 8'd127, 8'd127, 8'd63, 8'd63, 8'd63},
                    cycles: 16'd197};

        rst = 1'b1;
        #2 rst = 1'b0;
        #1 chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_job(vecs[i], -1);

        // Second start pulse lands in the division phase and must be ignored.
        run_job(vecs[1], 50);

        // Abort during the pixel phase, then restart with a tiny image.
        load_mem(vecs[0]);
        done_cnt  = 0;
        bus.dim   = vecs[0].dim;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (n < 205) begin
            @(negedge clk);
            n++;
        end
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1 chk_outputs_zero("abort");
        repeat (4) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        run_job(vecs[4], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eq_controller.md
# eq_controller

Histogram-equalization sequencer that runs after the histogram controller pulses `start`. It reads the NBINS summed bin counts from the histogram RAM and builds a cumulative distribution. It then converts that distribution into an 8-bit remap LUT using a sequential divider. Finally it streams the packed pixel memory through the LUT and writes the equalized words to the output pixel memory, pulsing `done` when finished.

## Interface
- `NBINS`, 8, number of histogram bins (power of two); bin index = top log2(NBINS) bits of a pixel
- `PIX_W`, 8, pixel width; four pixels are packed per 32-bit word, lane 0 in bits [7:0]
- `CNT_W`, 14, bin/CDF count width (max 126² = 15876)
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse from the histogram controller; histogram RAM is final
- `dim`  in  7  image side length; must be even, 0..126
- `hist_rd_data`  in  32  histogram RAM read data; only [CNT_W-1:0] used, synchronous, 1-cycle latency
- `addr_hist`  out  6  histogram RAM read address
- `pix_rd_data`  in  32  pixel RAM read data, 4 packed pixels, 1-cycle latency
- `addr_pix`  out  14  pixel RAM read address
- `WE_out`  out  1  output pixel RAM write enable
- `addr_out`  out  14  output pixel RAM write address
- `dataout_out`  out  32  remapped packed pixel word
- `busy`  out  1  high while a job is in progress
- `done`  out  1  one-cycle pulse on job completion

## Operation
- **Reset values:** all outputs 0. State IDLE. CDF accumulator, LUT and counters are cleared.
- **IDLE:** waits for `start`. Latches `dim`, sets total = dim², sets words = dim²>>2, then moves to HREAD.
  - If dim = 0: go directly to FIN, with no memory accesses and no writes.
- **HREAD:** drives `addr_hist` = 0..NBINS-1, one per cycle.
  - Data for address k returns one cycle later.
  - That data is added to the 14-bit running cdf, and cdf is stored into cdf_reg[k].
  - After the last bin is accumulated, moves to DIV.
- **DIV:** for b = 0..NBINS-1, computes lut[b] = floor(cdf_reg[b]·255 / total).
  - The 22-bit dividend is divided by the 14-bit divisor.
  - The result is ≤ 255 and is truncated to 8 bits.
  - One division per bin; the next division starts the cycle after the divider's `done`.
- **PRD:** drives `addr_pix` = word index w.
- **PWR:** the next cycle.
  - Lane i of `dataout_out` = lut[pix_rd_data[8i+7 : 8i+8-log2(NBINS)]].
  - `WE_out` = 1 and `addr_out` = w.
  - Then w increments. If w = words-1 was just written, go to FIN; otherwise go back to PRD.
- **FIN:** `done` = 1 for one cycle, `busy` = 0, return to IDLE.
- `start` while busy is ignored.
- `dim` changes after `start` are ignored, because `dim` is latched.
- Asserting `rst` mid-job aborts immediately:
  - `WE_out` drops asynchronously.
  - No `done` pulse is produced.
  - A later `start` begins a fresh job.
- **Widths:**
  - The cdf does not overflow for legal `dim`.
  - An odd `dim` is unsupported; words = floor(dim²/4) and the trailing pixels are not processed.

## Timing
- `busy` rises the cycle after `start` is sampled.
- **HREAD:** NBINS+1 cycles, including the trailing data cycle.
- **DIV:** NBINS × 23 cycles (1 load plus 22 restoring iterations).
- **Pixel phase:** 2 cycles per word, so 2·words cycles total.
  - `WE_out` is high only in PWR cycles and never on consecutive cycles.
- `done` is asserted the cycle after the last `WE_out`.
- `done` and `busy` are never high together.
- `addr_pix` and `addr_hist` hold 0 outside their own phases.

## Structure
- **Shared package `eq_pkg`:**
  - state localparams IDLE, HREAD, DIV, PRD, PWR, FIN
  - NBINS, PIX_W, CNT_W
  - LUT_MAX = 255
  - DIV_W = 22
- **Sub-module `seq_div`:** restoring divider, DIV_W/CNT_W.
  - Ports: clk, rst, go, dividend, divisor, quotient, done.
  - Fixed 22-iteration latency; `done` is a 1-cycle pulse.
- The LUT is an NBINS×8 register array. No RAM is inferred.

## Test plan
- **Uniform image:** dim = 8, 8 pixels in each bin, pixel value = bin<<5.
  - Required LUT: 31, 63, 95, 127, 159, 191, 223, 255.
  - Required: 16 writes, each output lane equal to the LUT entry for its input bin.
- **Constant image:** dim = 4, every pixel 0x40.
  - Required LUT: 0, 0, 255×6.
  - Required: 4 writes of 0xFFFFFFFF at `addr_out` 0..3, then a `done` pulse.
- **dim = 0:** `start` → `done` two cycles later; `WE_out` never asserted; `addr_hist` stays 0.
- **Start while busy:** `start` pulsed again during DIV → ignored. Exactly one `done`, and the write count equals the first job's.
- **Reset mid-job:** `rst` low during the pixel phase.
  - Required: all outputs 0 in the same cycle and no `done`.
  - A restart with dim = 2 produces exactly 1 correct write.
- **Cycle count:** dim = 8, NBINS = 8. Required: `start` → `done` = 1 + 9 + 184 + 32 + 1 cycles, checked exactly.
